rr_mux_reg: RTL and testbench

- Parametrised N-way, W-bit multiplexer with a valid/ready handshake on every input and a round-robin arbiter.
- Has a single registered output stage.
- Generalises the fixed 2-way/3-way combinational decode muxes: width and channel count are parametrised, and the block adds arbitration, backpressure and a registered select index.
- Sits in decode/util, between parallel decode lanes and the single downstream consumer.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_mux_reg_arbiter.sv | 69 ++++++
 rtl/rr_mux_reg.sv | 79 +++++++
 tb/tb_rr_mux_reg.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for the rr_mux_reg decode/util multiplexer.
package mux_pkg;

    localparam int DEF_N_CH  = 3;
    localparam int DEF_WIDTH = 4;

    // A single channel still needs a 1-bit index port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// Round-robin arbiter with a registered rotating pointer.
// Defining RR_MUX_REG_PRIO_EN swaps it for a fixed lowest-index-wins arbiter without a pointer.
module rr_arbiter import mux_pkg::*; #(
    parameter  int N_CH  = DEF_N_CH,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

`ifdef RR_MUX_REG_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance};

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end
`else
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] cand;
    logic             found;

    // Scan from ptr upward with wrap; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = SEL_W'((int'(ptr_q) + k) % N_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
    end

    if (N_CH == 1) begin : g_single
        logic unused_ok;
        assign ptr_q     = '0;
        assign unused_ok = ^{clk, rst, advance, ptr_d};
    end else begin : g_ptr
        // Pointer only moves on an accepted transfer, never on idle cycles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)          ptr_q <= '0;
            else if (advance) ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/rr_mux_reg.sv
// N-way valid/ready multiplexer with round-robin arbitration and one registered output stage.
// Build option RR_MUX_REG_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rr_mux_reg import mux_pkg::*; #(
    parameter  int N_CH  = DEF_N_CH,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } hs_t;

    hs_t              out_q, out_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             can_load;
    logic             xfer;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Output register accepts when empty or draining on this same edge.
    assign can_load = !out_q.valid || out_ready;
    assign in_ready = rst ? '0 : (grant & {N_CH{can_load}});
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_d = out_q;
        sel_d = sel_q;
        if (xfer) begin
            out_d.valid = 1'b1;
            out_d.data  = grant_data;
            sel_d       = grant_idx;
        end else if (out_q.valid && out_ready) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= '0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

    assign out_valid = out_q.valid;
    assign out_data  = out_q.data;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed + random bench for rr_mux_reg (N_CH=3, WIDTH=4) against a behavioural model.
module tb_rr_mux_reg;

    localparam int N = 3;
    localparam int W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*W-1:0]  in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [1:0]      out_sel;

    int checks = 0;
    int errors = 0;

    // Model state: what the output register should hold and where the search starts.
    int         m_ptr  = 0;
    logic       m_vld  = 1'b0;
    logic [3:0] m_data = '0;
    int         m_sel  = 0;

    rr_mux_reg #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        int start;
`ifdef RR_MUX_REG_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_vld  = 1'b0;
        m_data = '0;
        m_sel  = 0;
    endtask

    // Called at a negedge: drive, check ready, clock, check outputs, return at next negedge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        int         g;
        logic       can;
        logic [N-1:0] er;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        can = !m_vld || ordy;
        g   = pick(v);
        er  = (rst || !can || g < 0) ? '0 : N'(1 << g);
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (er != '0) begin
            m_vld  = 1'b1;
            m_data = d[g*W +: W];
            m_sel  = g;
            m_ptr  = (g + 1) % N;
        end else if (m_vld && ordy) begin
            m_vld = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_sel",   32'(out_sel),   32'(m_sel));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset held with no requests.
        repeat (3) step(3'b000, 12'h000, 1'b1);
        rst = 1'b0;

        // Single request on ch1.
        step(3'b010, 12'h0A0, 1'b1);
        chk("single_data", 32'(out_data), 32'h A);
        chk("single_sel",  32'(out_sel),  32'd1);
        step(3'b000, 12'h000, 1'b1);
        chk("single_drain", 32'(out_valid), 32'd0);

        // All three valid continuously.
        repeat (6) step(3'b111, 12'h321, 1'b1);

        // Backpressure: ch2 captured, consumer stalls while ch0 waits.
        step(3'b100, 12'h700, 1'b1);
        chk("bp_data", 32'(out_data), 32'h7);
        chk("bp_sel",  32'(out_sel),  32'd2);
        repeat (4) step(3'b001, 12'h005, 1'b0);
        chk("bp_hold", 32'(out_data), 32'h7);
        step(3'b001, 12'h005, 1'b1);
        chk("bp_release_sel", 32'(out_sel), 32'd0);

        // Wrap to ptr 0 then idle cycles must not move it.
        step(3'b100, 12'h900, 1'b1);
        repeat (3) step(3'b000, 12'h000, 1'b1);
        step(3'b011, 12'h021, 1'b1);
        chk("wrap_sel", 32'(out_sel), 32'd0);

        // Asynchronous reset while output is stalled and full.
        step(3'b010, 12'h0C0, 1'b1);
        step(3'b000, 12'h000, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_data",  32'(out_data),  32'd0);
        chk("async_sel",   32'(out_sel),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(3'b111, 12'h321, 1'b1);
        chk("post_reset_sel", 32'(out_sel), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step(N'($urandom), (N*W)'($urandom), ($urandom_range(0, 9) < 7));
        end
        rst = 1'b0;
        step(3'b000, 12'h000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
